// File: rtl/sha3_sponge_ctrl.sv
`timescale 1ns/1ps
// SHA3-256 sponge controller: absorbs 64-bit words with pad10*1, drives an external Keccak-f core, squeezes 4 digest lanes.
// Digest appears 26 cycles after the last word (52 if an extra pad block is needed); input stalls outside ABSORB, output holds while out_ready=0.
module sha3_sponge_ctrl (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             in_data,
    input  logic                    in_last,
    input  logic [3:0]              in_bytes,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_data,
    output logic                    out_last,
    output logic                    perm_start,
    output logic [4:0][4:0][63:0]   perm_state_in,
    input  logic                    perm_done,
    input  logic [4:0][4:0][63:0]   perm_state_out
);

    localparam logic [2:0]  S_ABSORB  = 3'd0;
    localparam logic [2:0]  S_PERM    = 3'd1;
    localparam logic [2:0]  S_WAIT    = 3'd2;
    localparam logic [2:0]  S_PAD     = 3'd3;
    localparam logic [2:0]  S_SQUEEZE = 3'd4;

    localparam logic [4:0]  LAST_LANE = 5'd16;
    localparam logic [63:0] PAD_LO    = 64'h0000_0000_0000_0006;
    localparam logic [63:0] PAD_HI    = 64'h8000_0000_0000_0000;

    typedef logic [4:0][4:0][63:0] state_t;

    logic [2:0]  r_fsm;
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_ocnt;
    logic        r_final;
    logic        r_pad_pending;

    logic [3:0]  w_bytes_eff;
    logic [63:0] w_word;
    state_t      w_absorb;
    state_t      w_pad_state;

    // Lane i lives at x = i mod 5, y = i div 5.
    function automatic state_t xor_lane(input state_t s, input logic [4:0] idx, input logic [63:0] v);
        state_t r;
        r = s;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                if (idx == 5'(x + 5 * y)) begin
                    r[x][y] = r[x][y] ^ v;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        w_bytes_eff = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        w_word      = in_data;
        for (int k = 0; k < 8; k++) begin
            if (in_last && (4'(k) >= w_bytes_eff)) begin
                w_word[8*k +: 8] = 8'h00;
            end
        end
        w_absorb = xor_lane(r_state, r_cnt, w_word);
        // A full last word pushes the 0x06 into the next lane; at lane 16 that needs a whole pad block.
        if (in_last && (w_bytes_eff < 4'd8)) begin
            w_absorb = xor_lane(w_absorb, r_cnt, PAD_LO << {w_bytes_eff[2:0], 3'b000});
            w_absorb = xor_lane(w_absorb, LAST_LANE, PAD_HI);
        end else if (in_last && (r_cnt < LAST_LANE)) begin
            w_absorb = xor_lane(w_absorb, r_cnt + 5'd1, PAD_LO);
            w_absorb = xor_lane(w_absorb, LAST_LANE, PAD_HI);
        end
        w_pad_state = xor_lane(xor_lane(r_state, 5'd0, PAD_LO), LAST_LANE, PAD_HI);
    end

    assign in_ready      = (r_fsm == S_ABSORB);
    assign out_valid     = (r_fsm == S_SQUEEZE);
    assign out_data      = out_valid ? r_state[{1'b0, r_ocnt}][0] : 64'h0;
    assign out_last      = out_valid && (r_ocnt == 2'd3);
    assign perm_start    = (r_fsm == S_PERM);
    assign perm_state_in = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm         <= S_ABSORB;
            r_state       <= '0;
            r_cnt         <= '0;
            r_ocnt        <= '0;
            r_final       <= 1'b0;
            r_pad_pending <= 1'b0;
        end else begin
            case (r_fsm)
                S_ABSORB: begin
                    if (in_valid) begin
                        r_state <= w_absorb;
                        if (!in_last) begin
                            if (r_cnt < LAST_LANE) begin
                                r_cnt <= r_cnt + 5'd1;
                            end else begin
                                r_fsm <= S_PERM;
                            end
                        end else begin
                            if ((w_bytes_eff < 4'd8) || (r_cnt < LAST_LANE)) begin
                                r_final <= 1'b1;
                            end else begin
                                r_pad_pending <= 1'b1;
                            end
                            r_fsm <= S_PERM;
                        end
                    end
                end
                S_PERM: begin
                    r_fsm <= S_WAIT;
                end
                // The core keeps iterating round 23, so only the first done cycle is captured.
                S_WAIT: begin
                    if (perm_done) begin
                        r_state <= perm_state_out;
                        if (r_final) begin
                            r_fsm <= S_SQUEEZE;
                        end else if (r_pad_pending) begin
                            r_fsm <= S_PAD;
                        end else begin
                            r_cnt <= '0;
                            r_fsm <= S_ABSORB;
                        end
                    end
                end
                S_PAD: begin
                    r_state       <= w_pad_state;
                    r_final       <= 1'b1;
                    r_pad_pending <= 1'b0;
                    r_fsm         <= S_PERM;
                end
                S_SQUEEZE: begin
                    if (out_ready) begin
                        if (r_ocnt == 2'd3) begin
                            r_state <= '0;
                            r_cnt   <= '0;
                            r_ocnt  <= '0;
                            r_final <= 1'b0;
                            r_fsm   <= S_ABSORB;
                        end else begin
                            r_ocnt <= r_ocnt + 2'd1;
                        end
                    end
                end
                default: begin
                    r_fsm <= S_ABSORB;
                end
            endcase
        end
    end

endmodule

// File: doc/sha3_sponge_ctrl.md
SHA3_SPONGE_CTRL -- requirements
Module: sha3_sponge_ctrl

Interface
- REQ-001: The block SHALL have no parameters; it is fixed to SHA3-256 (rate 17 lanes / 136 bytes, 4-lane digest).
- REQ-002: clk  input  1  sole clock; all state updates on posedge clk.
- REQ-003: rst  input  1  reset; one clock, synchronous, active-high.
- REQ-004: in_valid  input  1  message word valid.
- REQ-005: in_ready  output  1  block accepts the word this cycle.
- REQ-006: in_data  input  64  message word; byte k at bits [8k+7:8k] (little-endian).
- REQ-007: in_last  input  1  final word of the message.
- REQ-008: in_bytes  input  4  valid bytes in the final word (0..8); ignored unless in_last.
- REQ-009: out_valid  output  1  digest word valid.
- REQ-010: out_ready  input  1  consumer accepts the digest word.
- REQ-011: out_data  output  64  digest word, lanes 0..3 in order.
- REQ-012: out_last  output  1  marks the fourth digest word.
- REQ-013: perm_start  output  1  one-cycle start to the permutation core; loads perm_state_in.
- REQ-014: perm_state_in  output  1600  state to permute; packed [4:0][4:0][63:0], lane (x,y) at state[x][y].
- REQ-015: perm_done  input  1  core result valid (high when its round counter reads 23).
- REQ-016: perm_state_out  input  1600  core result, same packing.

Function
- REQ-017: Lane index i SHALL map to x = i mod 5, y = i div 5; word counter cnt (0..16) selects the absorb lane.
- REQ-018: The FSM SHALL have the states ABSORB, PERM, WAIT, PAD and SQUEEZE, with flags final and pad_pending.
- REQ-019: In ABSORB, in_ready SHALL be 1, and each handshake SHALL XOR in_data into lane cnt.
- REQ-020: When in_last is 1, in_bytes values 9..15 SHALL be treated as 8, and bytes at or above in_bytes SHALL be masked to 0.
- REQ-021: A non-last word with cnt<16 SHALL increment cnt; a non-last word with cnt=16 SHALL go to PERM.
- REQ-022: A last word with in_bytes<8 SHALL do all of the following in the same update, then set final and go to PERM:
  - XOR 0x06 into byte in_bytes of lane cnt;
  - XOR 0x80 into byte 7 of lane 16.
  - Coinciding pad bytes combine; for example, lane 16 with in_bytes=7 gives byte 7 = 0x86.
- REQ-023: A last word with in_bytes=8 and cnt<16 SHALL do all of the following, then set final and go to PERM:
  - XOR 0x06 into byte 0 of lane cnt+1;
  - XOR 0x80 into byte 7 of lane 16.
- REQ-024: A last word with in_bytes=8 and cnt=16 SHALL set pad_pending and go to PERM.
- REQ-025: PERM SHALL last exactly one cycle with perm_start=1 and perm_state_in equal to the state register, then go to WAIT; perm_state_in SHALL always reflect the state register.
- REQ-026: WAIT SHALL sample perm_done from the first WAIT cycle onward.
- REQ-027: On the first WAIT cycle where perm_done is 1, perm_state_out SHALL be captured exactly once.
  - This capture is required because the core keeps iterating round 23 afterward.
  - The perm_done level during the PERM cycle SHALL be ignored.
- REQ-028: After the capture, the next state SHALL be:
  - SQUEEZE if final is set;
  - otherwise PAD if pad_pending is set;
  - otherwise ABSORB with cnt=0.
- REQ-029: PAD SHALL take one cycle, then set final, clear pad_pending and go to PERM. In that cycle it SHALL:
  - XOR 0x06 into byte 0 of lane 0;
  - XOR 0x80 into byte 7 of lane 16.
- REQ-030: In SQUEEZE, out_valid SHALL be 1 and out_data SHALL be lane ocnt (0..3).
  - out_last SHALL be 1 when ocnt=3.
  - out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-031: The 4th squeeze handshake SHALL do all of the following:
  - zero the state;
  - clear cnt, ocnt and final;
  - return to ABSORB, with in_ready=1 on the next cycle.
- REQ-032: in_ready and out_valid SHALL never be 1 together; in_ready SHALL be 0 outside ABSORB.
- REQ-033: Latency from the last-word handshake in cycle T SHALL be:
  - perm_start at T+1;
  - capture at T+25;
  - out_valid at T+26 (single permutation), or T+52 when the pad_pending path is taken.

Reset
- REQ-034: Reset SHALL clear the state register, cnt, ocnt, final and pad_pending, and enter ABSORB.
- REQ-035: Reset values SHALL be: in_ready=1 on the first cycle after rst deasserts, out_valid=0, out_last=0, perm_start=0, out_data=0.
- REQ-036: Reset asserted during WAIT SHALL abandon the permutation; a later perm_done SHALL be ignored until a new PERM.

Verification
- REQ-037: Empty message (in_last=1, in_bytes=0) -> out_data word0=64'h66d71ebff8c6ffa7 (SHA3-256 "" = a7ffc6f8...8434a), out_last on word3.
- REQ-038: "abc" (in_data=64'h0000000000636261, in_bytes=3) -> word0=64'hb225e24fa75d983a; out_valid exactly 26 cycles after the handshake.
- REQ-039: 136-byte message (17 words, last with in_bytes=8) -> two perm_start pulses, PAD visited once, out_valid at T+52, digest matches the software model.
- REQ-040: 135-byte message (last with in_bytes=7 at lane 16) -> lane 16 byte 7 = 0x86, one permutation, digest matches the model.
- REQ-041: out_ready held 0 for 10 cycles in SQUEEZE -> out_data stable, in_ready=0, no extra perm_start.
- REQ-042: rst pulsed mid-WAIT, then "abc" hashed -> correct "abc" digest with no residue from the aborted message.
